// File: rtl/doorlock_supervisor_if.sv
// Keypad/core bundle for doorlock_supervisor.
// The master side drives keypad strobes and the core verdict. The slave side is the supervisor.
// Optional alarm output present when DOORLOCK_ALARM_EN is defined.
interface doorlock_supervisor_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       enter_btn;
    logic [1:0] core_result;
    logic [3:0] core_key;
    logic       core_flagpress;
    logic       core_enter;
    logic       core_clr;
    logic       unlock;
    logic       locked_out;
    logic [1:0] fail_count;
    logic [2:0] state;
`ifdef DOORLOCK_ALARM_EN
    logic       alarm;
`endif

    modport master (
        output key_valid, key_code, enter_btn, core_result,
`ifdef DOORLOCK_ALARM_EN
        input  alarm,
`endif
        input  core_key, core_flagpress, core_enter, core_clr,
               unlock, locked_out, fail_count, state
    );

    modport slave (
        input  key_valid, key_code, enter_btn, core_result,
`ifdef DOORLOCK_ALARM_EN
        output alarm,
`endif
        output core_key, core_flagpress, core_enter, core_clr,
               unlock, locked_out, fail_count, state
    );
endinterface

// File: rtl/doorlock_supervisor.sv
// doorlock_supervisor: sequences keypad strobes into the lock core and waits for its verdict.
// It then runs either a timed unlock window or a timed lockout.
// It clears the core after every attempt and when key entry goes idle.
// Optional feature: define DOORLOCK_ALARM_EN to add the registered alarm output.
module doorlock_supervisor #(
    parameter int MAX_FAILS     = 3,
    parameter int LOCK_CYCLES   = 1000,
    parameter int UNLOCK_CYCLES = 500,
    parameter int IDLE_TIMEOUT  = 2000,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    doorlock_supervisor_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_UNLOCK  = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    // Timers count down to zero, so a window of N cycles loads N-1.
    localparam logic [CNT_W-1:0] T_IDLE   = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] T_UNLOCK = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_LOCK   = CNT_W'(LOCK_CYCLES - 1);

    logic [2:0]       st;
    logic [CNT_W-1:0] timer;
    logic [1:0]       guard;
    logic [1:0]       fc;
    logic [3:0]       key_r;
    logic             fp_r, en_r, clr_r, unl_r, lo_r;

    logic             pass_hit, fail_hit, fail_trip;
    logic [1:0]       fc_inc;

    // Verdict decode: a silent core after the guard expires counts as invalid.
    always_comb begin
        pass_hit  = (st == S_WAIT) && (bus.core_result == 2'b01);
        fail_hit  = (st == S_WAIT) && (bus.core_result[1] ||
                    (bus.core_result == 2'b00 && guard == 2'd0));
        fc_inc    = (fc == 2'd3) ? 2'd3 : fc + 2'd1;
        fail_trip = int'({30'b0, fc_inc}) >= MAX_FAILS;
    end

    // Main sequencer; every output is a register updated here.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st    <= S_IDLE;
            timer <= '0;
            guard <= '0;
            fc    <= '0;
            key_r <= '0;
            fp_r  <= 1'b0;
            en_r  <= 1'b0;
            clr_r <= 1'b0;
            unl_r <= 1'b0;
            lo_r  <= 1'b0;
        end else begin
            fp_r <= 1'b0;
            en_r <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (bus.key_valid) begin
                        key_r <= bus.key_code;
                        fp_r  <= 1'b1;
                        timer <= T_IDLE;
                        st    <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    // A key in the same cycle as enter wins; that enter is dropped.
                    if (bus.key_valid) begin
                        key_r <= bus.key_code;
                        fp_r  <= 1'b1;
                        timer <= T_IDLE;
                    end else if (bus.enter_btn) begin
                        en_r  <= 1'b1;
                        guard <= 2'd3;
                        st    <= S_WAIT;
                    end else if (timer == '0) begin
                        clr_r <= 1'b1;
                        st    <= S_CLEAR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (pass_hit) begin
                        fc    <= 2'd0;
                        unl_r <= 1'b1;
                        timer <= T_UNLOCK;
                        st    <= S_UNLOCK;
                    end else if (fail_hit) begin
                        fc <= fc_inc;
                        if (fail_trip) begin
                            lo_r  <= 1'b1;
                            timer <= T_LOCK;
                            st    <= S_LOCKOUT;
                        end else begin
                            clr_r <= 1'b1;
                            st    <= S_CLEAR;
                        end
                    end else begin
                        guard <= guard - 2'd1;
                    end
                end
                S_UNLOCK: begin
                    if (timer == '0) begin
                        unl_r <= 1'b0;
                        clr_r <= 1'b1;
                        st    <= S_CLEAR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        lo_r  <= 1'b0;
                        fc    <= 2'd0;
                        clr_r <= 1'b1;
                        st    <= S_CLEAR;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_r <= 1'b0;
                    st    <= S_IDLE;
                end
                default: begin
                    unl_r <= 1'b0;
                    lo_r  <= 1'b0;
                    clr_r <= 1'b1;
                    st    <= S_CLEAR;
                end
            endcase
        end
    end

`ifdef DOORLOCK_ALARM_EN
    logic alarm_r;

    // Alarm covers the whole lockout plus a single pulse on each non-locking failure.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) alarm_r <= 1'b0;
        else     alarm_r <= fail_hit || (st == S_LOCKOUT && timer != '0);
    end

    assign bus.alarm = alarm_r;
`endif

    assign bus.core_key       = key_r;
    assign bus.core_flagpress = fp_r;
    assign bus.core_enter     = en_r;
    assign bus.core_clr       = clr_r;
    assign bus.unlock         = unl_r;
    assign bus.locked_out     = lo_r;
    assign bus.fail_count     = fc;
    assign bus.state          = st;
endmodule

// File: tb/tb_doorlock_supervisor.sv
// Self-checking bench for doorlock_supervisor: directed scenarios plus random traffic.
// Outputs are compared each cycle against a phase/remaining-cycles model of the lock rules.
module tb_doorlock_supervisor;
    localparam int MF = 3, LC = 8, UC = 4, IT = 6;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    doorlock_supervisor_if ifc();

    doorlock_supervisor #(.MAX_FAILS(MF), .LOCK_CYCLES(LC), .UNLOCK_CYCLES(UC),
                          .IDLE_TIMEOUT(IT), .CNT_W(16))
        dut (.clk(clk), .clr(clr), .bus(ifc.slave));

    int checks = 0, failures = 0;
    bit cmp_en = 0;

    // Model: phase number plus the cycles left in the current timed phase.
    int         ms, left, fc;
    logic [3:0] mkey;
    bit         mfp, men, mpulse;
    int         r_fc, r_unl, r_lo, r_fp, r_clr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; left = 0; fc = 0; mkey = 4'h0; mfp = 0; men = 0; mpulse = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc, input logic eb,
                              input logic [1:0] cr);
        int v;
        mfp = 0; men = 0; mpulse = 0;
        case (ms)
            0: if (kv) begin mkey = kc; mfp = 1; ms = 1; left = IT; end
            1: begin
                if (kv) begin mkey = kc; mfp = 1; left = IT; end
                else if (eb) begin men = 1; ms = 2; left = 4; end
                else begin left--; if (left == 0) ms = 4; end
            end
            2: begin
                v = int'(cr);
                left--;
                if (v == 0 && left == 0) v = 3;
                if (v == 1) begin fc = 0; ms = 3; left = UC; end
                else if (v != 0) begin
                    fc = (fc < 3) ? fc + 1 : 3;
                    mpulse = 1;
                    if (fc >= MF) begin ms = 5; left = LC; end
                    else ms = 4;
                end
            end
            3: begin left--; if (left == 0) ms = 4; end
            5: begin left--; if (left == 0) begin fc = 0; ms = 4; end end
            default: ms = 0;
        endcase
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state",      int'(ifc.state),          ms);
            chk("unlock",     int'(ifc.unlock),         int'(ms == 3));
            chk("locked_out", int'(ifc.locked_out),     int'(ms == 5));
            chk("core_clr",   int'(ifc.core_clr),       int'(ms == 4));
            chk("fail_count", int'(ifc.fail_count),     fc);
            chk("flagpress",  int'(ifc.core_flagpress), int'(mfp));
            chk("core_enter", int'(ifc.core_enter),     int'(men));
            chk("core_key",   int'(ifc.core_key),       int'(mkey));
`ifdef DOORLOCK_ALARM_EN
            chk("alarm",      int'(ifc.alarm),          int'(ms == 5 || mpulse));
`endif
        end
    end

    // One clock: drive at the falling edge, step the model at the rising edge, return at the next fall.
    task automatic cyc(input logic kv, input logic [3:0] kc, input logic eb, input logic [1:0] cr);
        ifc.key_valid = kv; ifc.key_code = kc; ifc.enter_btn = eb; ifc.core_result = cr;
        @(posedge clk);
        model_step(kv, kc, eb, cr);
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a low clock phase; outputs must clear at once.
    task automatic areset();
        ifc.key_valid = 0; ifc.enter_btn = 0; ifc.core_result = 2'b00;
        #2 clr = 1'b1;
        #1;
        chk("rst_state",      int'(ifc.state),          0);
        chk("rst_unlock",     int'(ifc.unlock),         0);
        chk("rst_locked_out", int'(ifc.locked_out),     0);
        chk("rst_fail_count", int'(ifc.fail_count),     0);
        chk("rst_core_clr",   int'(ifc.core_clr),       0);
        chk("rst_flagpress",  int'(ifc.core_flagpress), 0);
        chk("rst_core_key",   int'(ifc.core_key),       0);
`ifdef DOORLOCK_ALARM_EN
        chk("rst_alarm",      int'(ifc.alarm),          0);
`endif
        model_reset();
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Run until back in IDLE while throwing keys, enter and bogus verdicts at the block.
    task automatic settle();
        int k = 0;
        r_unl = int'(ifc.unlock); r_lo = int'(ifc.locked_out);
        r_clr = int'(ifc.core_clr); r_fp = 0;
        while (ms != 0 && k < 50) begin
            cyc(1'b1, 4'hA, 1'b1, 2'b01);
            r_unl += int'(ifc.unlock); r_lo += int'(ifc.locked_out);
            r_clr += int'(ifc.core_clr); r_fp += int'(ifc.core_flagpress);
            k++;
        end
        chk("settle_bound", int'(ms == 0), 1);
    endtask

    // Key in nk digits, press enter, deliver verdict v on the d-th WAIT_RES cycle.
    task automatic attempt(input int nk, input logic [11:0] digs, input logic [1:0] v,
                           input int d, input bit do_settle);
        logic [3:0] dg;
        for (int i = 0; i < nk; i++) begin
            dg = digs[11 - 4*i -: 4];
            cyc(1'b1, dg, 1'b0, 2'b00);
            chk("key_fwd", int'(ifc.core_key), int'(dg));
            chk("key_strobe", int'(ifc.core_flagpress), 1);
        end
        cyc(1'b0, 4'h0, 1'b1, 2'b00);
        chk("enter_fwd", int'(ifc.core_enter), 1);
        chk("enter_state", int'(ifc.state), 2);
        for (int i = 0; i < d; i++) cyc(1'b0, 4'h0, 1'b0, (i == d - 1) ? v : 2'b00);
        r_fc = int'(ifc.fail_count);
        if (do_settle) settle();
    endtask

    initial begin
        clr = 1'b1;
        ifc.key_valid = 0; ifc.key_code = 4'h0; ifc.enter_btn = 0; ifc.core_result = 2'b00;
        model_reset();
        #3;
        chk("init_state", int'(ifc.state), 0);
        chk("init_unlock", int'(ifc.unlock), 0);
        chk("init_fail_count", int'(ifc.fail_count), 0);
        @(negedge clk);
        clr = 1'b0;
        cmp_en = 1;

        // Enter from IDLE is ignored.
        cyc(1'b0, 4'h0, 1'b1, 2'b00);
        chk("idle_enter", int'(ifc.state), 0);

        // Pass: C,C,D then verdict two cycles later.
        attempt(3, 12'hCCD, 2'b01, 2, 1'b1);
        chk("pass_unlock_cycles", r_unl, 4);
        chk("pass_clr_pulses", r_clr, 1);
        chk("pass_no_strobe", r_fp, 0);
        chk("pass_end_state", int'(ifc.state), 0);

        // Fail, pass, fail.
        attempt(1, 12'h100, 2'b10, 1, 1'b1);
        chk("fpf_fc1", r_fc, 1);
        attempt(2, 12'h230, 2'b01, 3, 1'b1);
        chk("fpf_fc0", r_fc, 0);
        attempt(1, 12'h400, 2'b11, 2, 1'b1);
        chk("fpf_fc1b", r_fc, 1);
        chk("fpf_no_lockout", r_lo, 0);

        // Idle timeout after one key.
        cyc(1'b1, 4'h7, 1'b0, 2'b00);
        repeat (5) cyc(1'b0, 4'h0, 1'b0, 2'b00);
        chk("idle_still_entry", int'(ifc.state), 1);
        cyc(1'b0, 4'h0, 1'b0, 2'b00);
        chk("idle_clr", int'(ifc.core_clr), 1);
        cyc(1'b0, 4'h0, 1'b0, 2'b00);
        chk("idle_back", int'(ifc.state), 0);
        chk("idle_fc_kept", int'(ifc.fail_count), 1);

        // Key and enter together: key wins. Then a silent core times out as invalid.
        cyc(1'b1, 4'h3, 1'b0, 2'b00);
        cyc(1'b1, 4'h4, 1'b1, 2'b00);
        chk("both_strobe", int'(ifc.core_flagpress), 1);
        chk("both_no_enter", int'(ifc.core_enter), 0);
        chk("both_state", int'(ifc.state), 1);
        attempt(0, 12'h000, 2'b00, 4, 1'b0);
        chk("timeout_fc", r_fc, 2);
        chk("timeout_clear", int'(ifc.state), 4);
        settle();
        areset();

        // Three failures lead to an 8-cycle lockout that swallows keys.
        attempt(1, 12'h500, 2'b10, 1, 1'b1);
        chk("lo_fc1", r_fc, 1);
        attempt(1, 12'h600, 2'b10, 1, 1'b1);
        chk("lo_fc2", r_fc, 2);
        attempt(1, 12'h700, 2'b10, 1, 1'b1);
        chk("lo_fc3", r_fc, 3);
        chk("lo_cycles", r_lo, 8);
        chk("lo_no_strobe", r_fp, 0);
        chk("lo_fc_cleared", int'(ifc.fail_count), 0);

        // Reset in the third lockout cycle.
        attempt(1, 12'h800, 2'b11, 1, 1'b1);
        attempt(1, 12'h900, 2'b11, 1, 1'b1);
        attempt(1, 12'hA00, 2'b11, 1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 2'b00);
        cyc(1'b0, 4'h0, 1'b0, 2'b00);
        chk("lo3_active", int'(ifc.locked_out), 1);
        areset();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic kv, eb;
            logic [3:0] kc;
            logic [1:0] cr;
            kv = ($urandom_range(0, 99) < 30);
            eb = ($urandom_range(0, 99) < 20);
            kc = 4'($urandom);
            if (ms == 2) cr = ($urandom_range(0, 99) < 55) ? 2'b00 : 2'($urandom_range(1, 3));
            else         cr = 2'($urandom);
            if ($urandom_range(0, 599) == 0) areset();
            else cyc(kv, kc, eb, cr);
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
